// File: rtl/pattern_gen.sv
// pattern_gen: free-running video timing and test-pattern generator.
// Every output is the registered decode of the pre-edge (h, v) counter position.
module pattern_gen #(
  parameter logic [15:0] HSP     = 16'd6,
  parameter logic [15:0] HBP     = 16'd100,
  parameter logic [15:0] H_VAL   = 16'd1080,
  parameter logic [15:0] HFP     = 16'd60,
  parameter logic [15:0] H_TOTAL = 16'd1246,
  parameter logic [15:0] VSP     = 16'd6,
  parameter logic [15:0] VBP     = 16'd20,
  parameter logic [15:0] V_VAL   = 16'd1920,
  parameter logic [15:0] VFP     = 16'd10,
  parameter logic [15:0] V_TOTAL = 16'd1956
) (
  input  logic        px_clk,
  input  logic        rstn,
  output logic        hsync,
  output logic        vsync,
  output logic        dval,
  output logic [23:0] px_data,
  output logic        key,
  output logic        line_en
);

  // The active window is bounded by both the active count and the front porch,
  // so an inconsistent parameter set can never push dval into blanking.
  localparam logic [16:0] HA         = {1'b0, HSP} + {1'b0, HBP};
  localparam logic [16:0] HA_END_VAL = HA + {1'b0, H_VAL};
  localparam logic [16:0] HA_END_FP  = {1'b0, H_TOTAL} - {1'b0, HFP};
  localparam logic [16:0] HA_END     = (HA_END_VAL < HA_END_FP) ? HA_END_VAL : HA_END_FP;
  localparam logic [16:0] VA         = {1'b0, VSP} + {1'b0, VBP};
  localparam logic [16:0] VA_END_VAL = VA + {1'b0, V_VAL};
  localparam logic [16:0] VA_END_FP  = {1'b0, V_TOTAL} - {1'b0, VFP};
  localparam logic [16:0] VA_END     = (VA_END_VAL < VA_END_FP) ? VA_END_VAL : VA_END_FP;
  localparam logic [15:0] H_LAST     = H_TOTAL - 16'd1;
  localparam logic [15:0] V_LAST     = V_TOTAL - 16'd1;

  logic [15:0] r_h_cnt;
  logic [15:0] r_v_cnt;
  logic [7:0]  r_frame_cnt;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_line_en;
  logic        w_dval;
  logic        w_key;
  logic [7:0]  w_r;
  logic [7:0]  w_g;
  logic [23:0] w_px;

  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_en;
  logic        r_dval;
  logic        r_key;
  logic [23:0] r_px;

  function automatic logic in_window(input logic [15:0] pos,
                                     input logic [16:0] lo,
                                     input logic [16:0] hi);
    in_window = ({1'b0, pos} >= lo) && ({1'b0, pos} < hi);
  endfunction

  // Decode of the current counter position.
  always_comb begin
    w_h_last  = (r_h_cnt == H_LAST);
    w_v_last  = (r_v_cnt == V_LAST);
    w_hsync   = (r_h_cnt < HSP);
    w_vsync   = (r_v_cnt < VSP);
    w_line_en = in_window(r_v_cnt, VA, VA_END);
    w_dval    = w_line_en && in_window(r_h_cnt, HA, HA_END);
    w_key     = (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
    w_r       = r_h_cnt[7:0] - HA[7:0];
    w_g       = r_v_cnt[7:0] - VA[7:0];
    if (w_dval) begin
      w_px = {w_r, w_g, r_frame_cnt};
    end else begin
      w_px = 24'h000000;
    end
  end

  // Raster position and frame counters.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_h_cnt     <= 16'd0;
      r_v_cnt     <= 16'd0;
      r_frame_cnt <= 8'd0;
    end else if (w_h_last) begin
      r_h_cnt <= 16'd0;
      if (w_v_last) begin
        r_v_cnt     <= 16'd0;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else begin
        r_v_cnt <= r_v_cnt + 16'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 16'd1;
    end
  end

  // Output registers: one cycle behind the counters.
  always_ff @(posedge px_clk or negedge rstn) begin
    if (!rstn) begin
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_line_en <= 1'b0;
      r_dval    <= 1'b0;
      r_key     <= 1'b0;
      r_px      <= 24'h000000;
    end else begin
      r_hsync   <= w_hsync;
      r_vsync   <= w_vsync;
      r_line_en <= w_line_en;
      r_dval    <= w_dval;
      r_key     <= w_key;
      r_px      <= w_px;
    end
  end

  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign line_en = r_line_en;
  assign dval    = r_dval;
  assign key     = r_key;
  assign px_data = r_px;

endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: two small timing configurations checked every cycle
// against a raster-position model, with randomly timed asynchronous resets.
module tb_pattern_gen;

  logic        px_clk = 1'b0;
  logic        rstn   = 1'b0;

  logic        a_hsync, a_vsync, a_dval, a_key, a_line_en;
  logic [23:0] a_px;
  logic        b_hsync, b_vsync, b_dval, b_key, b_line_en;
  logic [23:0] b_px;

  int          total = 0;
  int          bad   = 0;
  int unsigned n_edges;

  int          win_hs, win_vs, win_de, win_le, win_key, win_hrise;
  logic        prev_hs;

  always #5 px_clk = ~px_clk;

  // Small config: 10 x 5 raster, 4 x 2 active.
  pattern_gen #(
    .HSP(16'd2), .HBP(16'd3), .H_VAL(16'd4), .HFP(16'd1), .H_TOTAL(16'd10),
    .VSP(16'd1), .VBP(16'd1), .V_VAL(16'd2), .VFP(16'd1), .V_TOTAL(16'd5)
  ) dut_a (
    .px_clk(px_clk), .rstn(rstn), .hsync(a_hsync), .vsync(a_vsync),
    .dval(a_dval), .px_data(a_px), .key(a_key), .line_en(a_line_en)
  );

  // Zero porches and a line wider than 256 pixels.
  pattern_gen #(
    .HSP(16'd1), .HBP(16'd0), .H_VAL(16'd260), .HFP(16'd0), .H_TOTAL(16'd261),
    .VSP(16'd1), .VBP(16'd0), .V_VAL(16'd2), .VFP(16'd0), .V_TOTAL(16'd3)
  ) dut_b (
    .px_clk(px_clk), .rstn(rstn), .hsync(b_hsync), .vsync(b_vsync),
    .dval(b_dval), .px_data(b_px), .key(b_key), .line_en(b_line_en)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%h exp=%h", name, n_edges, got, exp);
    end
  endtask

  // Expected {hsync, vsync, dval, line_en, key, px} for the p-th position after reset.
  function automatic logic [28:0] model(input int hsp, input int hbp, input int hval, input int hfp,
                                        input int vsp, input int vbp, input int vval, input int vfp,
                                        input int p);
    int ht, vt, fr, w, h, v, ha, va;
    logic hs, vs, le, de, k;
    logic [23:0] px;
    ht = hsp + hbp + hval + hfp;
    vt = vsp + vbp + vval + vfp;
    fr = (p / (ht * vt)) % 256;
    w  = p % (ht * vt);
    v  = w / ht;
    h  = w % ht;
    ha = hsp + hbp;
    va = vsp + vbp;
    hs = (h < hsp);
    vs = (v < vsp);
    le = (v >= va) && (v < va + vval);
    de = le && (h >= ha) && (h < ha + hval);
    k  = (h == 0) && (v == 0);
    px = de ? {8'(h - ha), 8'(v - va), 8'(fr)} : 24'h000000;
    return {hs, vs, de, le, k, px};
  endfunction

  // Edges seen since the last reset release.
  always @(posedge px_clk or negedge rstn) begin
    if (!rstn) n_edges <= 32'd0;
    else       n_edges <= n_edges + 32'd1;
  end

  // Per-cycle compare, literal pins and per-frame statistics.
  always @(negedge px_clk) begin
    logic [28:0] ea, eb, ga, gb;
    ga = {a_hsync, a_vsync, a_dval, a_line_en, a_key, a_px};
    gb = {b_hsync, b_vsync, b_dval, b_line_en, b_key, b_px};
    if (!rstn || n_edges == 32'd0) begin
      ea = 29'd0;
      eb = 29'd0;
    end else begin
      ea = model(2, 3, 4, 1, 1, 1, 2, 1, int'(n_edges) - 1);
      eb = model(1, 0, 260, 0, 1, 0, 2, 0, int'(n_edges) - 1);
    end
    chk("cycle_a", 32'(ga), 32'(ea));
    chk("cycle_b", 32'(gb), 32'(eb));

    if (!rstn || n_edges == 32'd0) begin
      win_hs = 0; win_vs = 0; win_de = 0; win_le = 0; win_key = 0; win_hrise = 0;
      prev_hs = 1'b0;
    end else begin
      if (n_edges == 32'd1)
        chk("first_edge", 32'({a_hsync, a_vsync, a_key, a_dval}), 32'h0000000E);
      if (n_edges >= 32'd21 && n_edges <= 32'd30)
        chk("line2_en", 32'(a_line_en), 32'd1);
      if (n_edges >= 32'd26 && n_edges <= 32'd29)
        chk("line2_px", 32'({a_dval, a_px}), {8'h01, 8'(n_edges - 32'd26), 16'h0000});
      if (n_edges == 32'd36)
        chk("line3_g", 32'({a_dval, a_px}), 32'h01000100);
      if (n_edges == 32'd76)
        chk("frame1_b", 32'({a_dval, a_px}), 32'h01000001);
      if (n_edges == 32'd12776)
        chk("frame255_b", 32'({a_dval, a_px}), 32'h010000FF);
      if (n_edges == 32'd12826)
        chk("frame256_b", 32'({a_dval, a_px}), 32'h01000000);
      if (n_edges == 32'd519)
        chk("wide_wrap0", 32'({b_dval, b_px}), 32'h01000000);
      if (n_edges == 32'd522)
        chk("wide_wrap3", 32'({b_dval, b_px}), 32'h01030000);

      win_hs    += int'(a_hsync);
      win_vs    += int'(a_vsync);
      win_de    += int'(a_dval);
      win_le    += int'(a_line_en);
      win_key   += int'(a_key);
      win_hrise += int'(a_hsync && !prev_hs);
      prev_hs    = a_hsync;
      if (n_edges % 32'd50 == 32'd0) begin
        chk("frame_hsync_cycles", 32'(win_hs), 32'd10);
        chk("frame_hsync_rises", 32'(win_hrise), 32'd5);
        chk("frame_vsync_cycles", 32'(win_vs), 32'd10);
        chk("frame_dval_cycles", 32'(win_de), 32'd8);
        chk("frame_line_en_cycles", 32'(win_le), 32'd20);
        chk("frame_key_pulses", 32'(win_key), 32'd1);
        win_hs = 0; win_vs = 0; win_de = 0; win_le = 0; win_key = 0; win_hrise = 0;
      end
    end
  end

  initial begin
    logic found;
    rstn = 1'b0;
    repeat (3) @(negedge px_clk);
    @(negedge px_clk) rstn = 1'b1;

    // 257 frames of the small raster plus a little of the next one.
    repeat (257 * 50 + 30) @(posedge px_clk);

    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
          @(posedge px_clk);
          #1;
          if (a_dval) found = 1'b1;
        end
        chk("find_active_line", 32'(found), 32'd1);
      end else begin
        repeat ($urandom_range(20, 600)) @(posedge px_clk);
        #1;
      end
      #2 rstn = 1'b0;
      #1;
      chk("async_clear_a", 32'({a_hsync, a_vsync, a_dval, a_line_en, a_key, a_px}), 32'd0);
      chk("async_clear_b", 32'({b_hsync, b_vsync, b_dval, b_line_en, b_key, b_px}), 32'd0);
      repeat ($urandom_range(1, 3)) @(negedge px_clk);
      @(negedge px_clk) rstn = 1'b1;
    end

    repeat (200) @(posedge px_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Free-running video timing and test-pattern generator.
- Produces DPI-style hsync, vsync, data-valid and 24-bit RGB pixel data from programmable horizontal and vertical timing.
- Driven by the pixel clock; feeds display/MIPI host models and DPI sinks with a deterministic, checkable pattern.

Parameters:
- HSP, 16'd6: hsync pulse width, pixel clocks.
- HBP, 16'd100: horizontal back porch, pixel clocks.
- H_VAL, 16'd1080: active pixels per line.
- HFP, 16'd60: horizontal front porch, pixel clocks.
- H_TOTAL, 16'd1246: line length; must equal HSP+HBP+H_VAL+HFP.
- VSP, 16'd6: vsync pulse width, lines.
- VBP, 16'd20: vertical back porch, lines.
- V_VAL, 16'd1920: active lines per frame.
- VFP, 16'd10: vertical front porch, lines.
- V_TOTAL, 16'd1956: frame length; must equal VSP+VBP+V_VAL+VFP.

Ports:
- px_clk, input, 1: pixel clock; all logic on rising edge.
- rstn, input, 1: reset, asynchronous, active-low.
- hsync, output, 1: horizontal sync, active high.
- vsync, output, 1: vertical sync, active high.
- dval, output, 1: pixel data valid (active area).
- px_data, output, 24: pixel data {R[23:16], G[15:8], B[7:0]}.
- key, output, 1: one-cycle frame-start strobe.
- line_en, output, 1: high for the whole of every active line.

Behaviour:
- Single clock domain (px_clk); rstn asynchronous, active-low.
- Internal counters, all reset to 0:
  - h_cnt, 16 bit, range 0..H_TOTAL-1.
  - v_cnt, 16 bit, range 0..V_TOTAL-1.
  - frame_cnt, 8 bit.
- Counter update each clock:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; frame_cnt increments (mod 256) on that same edge.
- Outputs are registered. On each rising edge they load the decoded value of the pre-edge (h_cnt, v_cnt), giving exactly one cycle of latency from counters to outputs.
- Reset values: all outputs 0.
- First edge after reset release loads the decode of (0,0), so hsync=1, vsync=1 and key=1. vsync therefore shows a rising edge immediately after reset.
- Decode, with HA = HSP+HBP and VA = VSP+VBP:
  - hsync = (h < HSP). Line order is sync, back porch, active, front porch.
  - vsync = (v < VSP). Asserts and deasserts on the same cycle as the hsync rising edge of the line.
  - line_en = (VA <= v < VA+V_VAL).
  - dval = line_en && (HA <= h < HA+H_VAL).
  - key = (h==0 && v==0).
  - When dval: px_data = {(h-HA)[7:0], (v-VA)[7:0], frame_cnt}. Otherwise px_data = 24'h0.
- Per frame:
  - Exactly V_VAL×H_VAL dval cycles.
  - V_TOTAL hsync pulses, each HSP cycles long.
  - One vsync pulse of VSP×H_TOTAL cycles.
- Wrap-around: the R and G fields wrap modulo 256 for H_VAL/V_VAL > 256.
- Reset asserted mid-frame: outputs clear to 0 immediately (asynchronously); counters restart from (0,0), frame_cnt from 0.
- Degenerate parameters: HSP=0 or VSP=0 is not supported. Porch values of 0 are supported.

Test Plan:
- Small timing (HSP=2, HBP=3, H_VAL=4, HFP=1, H_TOTAL=10; VSP=1, VBP=1, V_VAL=2, VFP=1, V_TOTAL=5), release reset:
  - first edge: hsync=1, vsync=1, key=1, dval=0.
  - hsync high for 2 cycles of every 10.
  - vsync high for 10 cycles of every 50.
- Same config, line v=2:
  - line_en=1 for all 10 cycles.
  - dval=1 on output cycles 6..9 of the line, px_data = 24'h000000, 010000, 020000, 030000.
  - line v=3 shows G=01.
- Same config, second frame: B field = 01 on all active pixels; key pulses exactly once per 50 cycles.
- Default parameters, one frame:
  - count dval cycles = 2,073,600.
  - hsync rising edges = 1956.
  - vsync high length = 7476 cycles.
- Assert rstn mid-active-line: all outputs 0 asynchronously; after release the sequence restarts identically to the first frame (B=00).
- Run 257 frames at small config: frame_cnt wraps, B returns to 00 on frame 257.
